// File: rtl/cbm2_bus_sequencer_pkg.sv
// CBM-II bus sequencer shared types and default timing constants.
package cbm2_pkg;

   localparam int PHASE_CLKS_DEF     = 16;
   localparam int REQ_AT_DEF         = 2;
   localparam int REFRESH_CYCLES_DEF = 15;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_WAIT,
      ACC_DONE
   } acc_state_t;

endpackage

// File: rtl/cbm2_bus_sequencer_if.sv
// SDRAM request/acknowledge bundle between the bus sequencer and the controller.
interface cbm2_bus_sequencer_if;

   logic        sdram_req;
   logic        sdram_we;
   logic [24:0] sdram_addr;
   logic [7:0]  sdram_din;
   logic        sdram_refresh;
   logic        sdram_ack;
   logic [7:0]  sdram_dout;

   modport master (
      output sdram_req, sdram_we, sdram_addr, sdram_din, sdram_refresh,
      input  sdram_ack, sdram_dout
   );

   modport slave (
      input  sdram_req, sdram_we, sdram_addr, sdram_din, sdram_refresh,
      output sdram_ack, sdram_dout
   );

endinterface

// File: rtl/cbm2_bus_sequencer_refresh.sv
// DRAM refresh interval counter; issues a refresh in the first free video slot.
module cbm2_refresh_timer
   import cbm2_pkg::*;
#(
   parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic sys_wrap,
   input  logic slot_free,
   output logic refresh
);

   localparam int RW = $clog2(REFRESH_CYCLES + 1);

   logic [RW-1:0] refcnt;
   logic          pending;
   logic          issue;

   assign pending = refcnt == RW'(REFRESH_CYCLES);
   assign issue   = pending && slot_free;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         refcnt  <= '0;
         refresh <= 1'b0;
      end else begin
         refresh <= issue;
         if (issue)
            refcnt <= '0;
         else if (sys_wrap && !pending)
            refcnt <= refcnt + RW'(1);
      end
   end

endmodule

// File: rtl/cbm2_bus_sequencer.sv
// CBM-II master bus-cycle generator: video/CPU slots, SDRAM handshake, refresh.
module cbm2_bus_sequencer
   import cbm2_pkg::*;
#(
   parameter int PHASE_CLKS     = PHASE_CLKS_DEF,
   parameter int REQ_AT         = REQ_AT_DEF,
   parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        pause,
   input  logic        model,
   input  logic        cs_ram,
   input  logic [24:0] systemAddr,
   input  logic        systemWe,
   input  logic [7:0]  cpuDo,
   output logic        phase,
   output logic        cpuCycle,
   output logic        vidCycle,
   output logic        enableCpu,
   output logic        enableVid,
   output logic [7:0]  ramData,
   output logic        ramLate,
   cbm2_bus_sequencer_if.master sdram
);

   localparam int CW = $clog2(PHASE_CLKS);

   logic [CW-1:0] cnt;
   logic          pause_l;
   logic          last;
   logic          sys_wrap;
   logic          sample;
   logic          req_now;
   logic          slot_free;
   logic          stale;
   logic          acc_ack;
   logic          acc_late;
   acc_state_t    state;
   acc_state_t    state_nx;

   assign last      = cnt == CW'(PHASE_CLKS - 1);
   assign sys_wrap  = last && phase;
   assign sample    = cnt == CW'(REQ_AT - 1);
   assign req_now   = sample && (vidCycle || cpuCycle) && cs_ram;
   assign slot_free = sample && vidCycle && (model || !cs_ram) && !req_now;
   assign enableCpu = cpuCycle && last;
   assign enableVid = vidCycle && last;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt      <= '0;
         phase    <= 1'b0;
         vidCycle <= 1'b1;
         cpuCycle <= 1'b0;
         pause_l  <= 1'b0;
      end else begin
         cnt <= last ? '0 : cnt + CW'(1);
         if (sys_wrap)
            pause_l <= pause;
         if (last) begin
            phase    <= ~phase;
            vidCycle <= phase;
            cpuCycle <= ~phase & ~pause_l;
         end
      end
   end

   // Registered so the strobe and its address appear together at cnt == REQ_AT.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sdram.sdram_req  <= 1'b0;
         sdram.sdram_we   <= 1'b0;
         sdram.sdram_addr <= '0;
         sdram.sdram_din  <= '0;
      end else begin
         sdram.sdram_req <= req_now;
         if (req_now) begin
            sdram.sdram_addr <= systemAddr;
            sdram.sdram_we   <= systemWe;
            sdram.sdram_din  <= cpuDo;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= ACC_IDLE;
         ramData <= 8'hFF;
         ramLate <= 1'b0;
         stale   <= 1'b0;
      end else begin
         state <= state_nx;
         if (acc_ack && !sdram.sdram_we)
            ramData <= sdram.sdram_dout;
         else if (acc_late)
            ramData <= 8'hFF;
         if (acc_late)
            ramLate <= 1'b1;
         // A timed-out access still owes one ack; swallow it.
         if (acc_late)
            stale <= 1'b1;
         else if (sdram.sdram_ack)
            stale <= 1'b0;
      end
   end

   always_comb begin
      state_nx = state;
      acc_ack  = 1'b0;
      acc_late = 1'b0;
      unique case (state)
         ACC_IDLE: begin
            if (sdram.sdram_req)
               state_nx = ACC_WAIT;
         end
         ACC_WAIT: begin
            if (sdram.sdram_ack && !stale) begin
               acc_ack  = 1'b1;
               state_nx = ACC_DONE;
            end else if (cnt == CW'(PHASE_CLKS - 2)) begin
               acc_late = 1'b1;
               state_nx = ACC_DONE;
            end
         end
         ACC_DONE: begin
            if (last)
               state_nx = ACC_IDLE;
         end
         default: state_nx = ACC_IDLE;
      endcase
   end

   cbm2_refresh_timer #(
      .REFRESH_CYCLES(REFRESH_CYCLES)
   ) u_refresh (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .sys_wrap (sys_wrap),
      .slot_free(slot_free),
      .refresh  (sdram.sdram_refresh)
   );

endmodule

// File: tb/tb_cbm2_bus_sequencer.sv
// Bench for cbm2_bus_sequencer: vector table, hand sequences, random vs model.
module tb_cbm2_bus_sequencer;

   localparam int P  = 16;
   localparam int RA = 2;
   localparam int RC = 15;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        pause = 1'b0;
   logic        model = 1'b0;
   logic        cs_ram = 1'b0;
   logic [24:0] systemAddr = '0;
   logic        systemWe = 1'b0;
   logic [7:0]  cpuDo = '0;
   logic        phase, cpuCycle, vidCycle, enableCpu, enableVid, ramLate;
   logic [7:0]  ramData;

   cbm2_bus_sequencer_if sd();

   cbm2_bus_sequencer #(
      .PHASE_CLKS(16), .REQ_AT(2), .REFRESH_CYCLES(15)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .pause(pause), .model(model),
      .cs_ram(cs_ram), .systemAddr(systemAddr), .systemWe(systemWe),
      .cpuDo(cpuDo), .phase(phase), .cpuCycle(cpuCycle),
      .vidCycle(vidCycle), .enableCpu(enableCpu), .enableVid(enableVid),
      .ramData(ramData), .ramLate(ramLate), .sdram(sd)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic        slot;
      logic        we;
      logic [24:0] addr;
      logic [7:0]  din;
      int          dly;
      logic [7:0]  dout;
      logic [7:0]  exp_data;
      logic        exp_late;
   } acc_vec_t;

   acc_vec_t tv [7];

   int vectors = 0;
   int errors  = 0;
   int t = 0;

   // reference model state
   logic        m_paused, m_data_late, m_open, m_stale, m_we;
   logic        m_req, m_ref_f;
   logic [7:0]  m_data, m_din, ack_val;
   logic [24:0] m_addr;
   int          m_ref, m_slot, ack_at;
   int          c, ph, tp;
   logic        i_cs, i_we, i_ack, i_pause, i_model;
   logic [24:0] i_addr;
   logic [7:0]  i_din, i_dout;
   int          ref_q [$];
   int          both;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d: got %0h want %0h", name, t, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      @(negedge clk_sys);
      t++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pause = 1'b0;
      cs_ram = 1'b0;
      sd.sdram_ack = 1'b0;
      sd.sdram_dout = 8'h00;
      @(posedge clk_sys);
      @(negedge clk_sys);
      reset = 1'b0;
      t = 0;
   endtask

   task automatic goto_slot(input int s);
      while (!((t % P) == 0 && ((t / P) % 2) == s)) tick();
   endtask

   task automatic goto_cnt(input int k);
      while ((t % P) != k) tick();
   endtask

   initial begin
      tv[0] = '{1'b1, 1'b0, 25'h0012345, 8'h00, 4,  8'hA5, 8'hA5, 1'b0};
      tv[1] = '{1'b1, 1'b1, 25'h0000100, 8'h3C, 3,  8'h11, 8'hA5, 1'b0};
      tv[2] = '{1'b1, 1'b0, 25'h1FFFFFF, 8'h00, 12, 8'h5A, 8'h5A, 1'b0};
      tv[3] = '{1'b0, 1'b0, 25'h00000AA, 8'h00, 1,  8'h00, 8'h00, 1'b0};
      tv[4] = '{1'b0, 1'b1, 25'h1ABCDE0, 8'hC3, 7,  8'h99, 8'h00, 1'b0};
      tv[5] = '{1'b1, 1'b0, 25'h0000001, 8'h00, 11, 8'h81, 8'h81, 1'b0};
      tv[6] = '{1'b1, 1'b0, 25'h00000FF, 8'h00, -1, 8'h00, 8'hFF, 1'b1};

      // reset state
      do_reset();
      chk("rst_phase", 32'(phase), 0);
      chk("rst_vid", 32'(vidCycle), 1);
      chk("rst_cpu", 32'(cpuCycle), 0);
      chk("rst_envid", 32'(enableVid), 0);
      chk("rst_encpu", 32'(enableCpu), 0);
      chk("rst_req", 32'(sd.sdram_req), 0);
      chk("rst_refresh", 32'(sd.sdram_refresh), 0);
      chk("rst_addr", 32'(sd.sdram_addr), 0);
      chk("rst_din", 32'(sd.sdram_din), 0);
      chk("rst_data", 32'(ramData), 32'hFF);
      chk("rst_late", 32'(ramLate), 0);

      // free run
      for (int k = 0; k < 64; k++) begin
         chk("fr_phase", 32'(phase), 32'((k / 16) % 2));
         chk("fr_envid", 32'(enableVid), 32'(k == 15 || k == 47));
         chk("fr_encpu", 32'(enableCpu), 32'(k == 31 || k == 63));
         tick();
      end

      // access table
      do_reset();
      foreach (tv[i]) begin
         goto_slot(int'(tv[i].slot));
         cs_ram = 1'b1;
         systemAddr = tv[i].addr;
         systemWe = tv[i].we;
         cpuDo = tv[i].din;
         goto_cnt(RA);
         chk("tv_req", 32'(sd.sdram_req), 1);
         chk("tv_addr", 32'(sd.sdram_addr), 32'(tv[i].addr));
         chk("tv_we", 32'(sd.sdram_we), 32'(tv[i].we));
         if (tv[i].we) chk("tv_din", 32'(sd.sdram_din), 32'(tv[i].din));
         cs_ram = 1'b0;
         tick();
         chk("tv_req_pulse", 32'(sd.sdram_req), 0);
         if (tv[i].dly > 0) begin
            repeat (tv[i].dly - 1) tick();
            sd.sdram_ack = 1'b1;
            sd.sdram_dout = tv[i].dout;
            tick();
            sd.sdram_ack = 1'b0;
            sd.sdram_dout = 8'h00;
         end
         goto_cnt(P - 1);
         chk("tv_data", 32'(ramData), 32'(tv[i].exp_data));
         chk("tv_late", 32'(ramLate), 32'(tv[i].exp_late));
         if (tv[i].slot) chk("tv_encpu", 32'(enableCpu), 1);
         else chk("tv_envid", 32'(enableVid), 1);
      end

      // late ack in the following slot is ignored
      goto_slot(0);
      goto_cnt(3);
      sd.sdram_ack = 1'b1;
      sd.sdram_dout = 8'h77;
      tick();
      sd.sdram_ack = 1'b0;
      goto_cnt(P - 1);
      chk("stray_data", 32'(ramData), 32'hFF);
      chk("stray_late", 32'(ramLate), 1);

      // reset in the middle of an access
      goto_slot(1);
      cs_ram = 1'b1;
      systemWe = 1'b0;
      goto_cnt(5);
      do_reset();
      chk("mid_rst_late", 32'(ramLate), 0);
      tick();
      sd.sdram_ack = 1'b1;
      sd.sdram_dout = 8'h12;
      tick();
      sd.sdram_ack = 1'b0;
      tick();
      chk("mid_rst_data", 32'(ramData), 32'hFF);

      // refresh held off by busy video slots
      do_reset();
      model = 1'b0;
      systemWe = 1'b1;
      both = 0;
      ref_q.delete();
      while (t < 37 * 32) begin
         cs_ram = ((t / P) % 2 == 0) && (t / 32 < 20);
         if (sd.sdram_refresh) ref_q.push_back(t);
         if (sd.sdram_refresh && sd.sdram_req) both++;
         tick();
      end
      cs_ram = 1'b0;
      chk("ref_count", 32'(ref_q.size()), 2);
      chk("ref_first", 32'(ref_q.size() > 0 ? ref_q[0] : -1), 32'(20 * 32 + 2));
      chk("ref_second", 32'(ref_q.size() > 1 ? ref_q[1] : -1), 32'(35 * 32 + 2));
      chk("ref_with_req", 32'(both), 0);

      // pause for three system cycles, raised mid CPU slot
      do_reset();
      cs_ram = 1'b1;
      systemWe = 1'b0;
      while (t < 160) begin
         int cyc;
         logic ps;
         if (t == 20) pause = 1'b1;
         if (t == 116) pause = 1'b0;
         cyc = t / 32;
         ps = (cyc >= 1 && cyc <= 3);
         c = t % P;
         ph = (t / P) % 2;
         chk("pz_cpu", 32'(cpuCycle), 32'(ph == 1 && !ps));
         chk("pz_encpu", 32'(enableCpu), 32'(ph == 1 && !ps && c == P - 1));
         chk("pz_envid", 32'(enableVid), 32'(ph == 0 && c == P - 1));
         chk("pz_req", 32'(sd.sdram_req), 32'(c == RA && (ph == 0 || !ps)));
         tick();
      end
      cs_ram = 1'b0;

      // randomized run against the slot-level model
      do_reset();
      m_paused = 0; m_data_late = 0; m_open = 0; m_stale = 0; m_we = 0;
      m_req = 0; m_ref_f = 0; m_data = 8'hFF; m_din = 0; m_addr = 0;
      m_ref = 0; m_slot = -1; ack_at = -1; ack_val = 0;
      for (int n = 0; n < 4000; n++) begin
         c = t % P;
         ph = (t / P) % 2;
         chk("rn_phase", 32'(phase), 32'(ph));
         chk("rn_vid", 32'(vidCycle), 32'(ph == 0));
         chk("rn_cpu", 32'(cpuCycle), 32'(ph == 1 && !m_paused));
         chk("rn_envid", 32'(enableVid), 32'(ph == 0 && c == P - 1));
         chk("rn_encpu", 32'(enableCpu), 32'(ph == 1 && !m_paused && c == P - 1));
         chk("rn_req", 32'(sd.sdram_req), 32'(m_req));
         chk("rn_refresh", 32'(sd.sdram_refresh), 32'(m_ref_f));
         if (m_req) begin
            chk("rn_addr", 32'(sd.sdram_addr), 32'(m_addr));
            chk("rn_we", 32'(sd.sdram_we), 32'(m_we));
            chk("rn_din", 32'(sd.sdram_din), 32'(m_din));
         end
         chk("rn_data", 32'(ramData), 32'(m_data));
         chk("rn_late", 32'(ramLate), 32'(m_data_late));

         cs_ram = ($urandom_range(0, 2) != 0);
         systemAddr = 25'($urandom);
         systemWe = 1'($urandom_range(0, 1));
         cpuDo = 8'($urandom);
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         if (c == 0) model = 1'($urandom_range(0, 1));
         sd.sdram_ack = (t == ack_at);
         sd.sdram_dout = sd.sdram_ack ? ack_val : 8'($urandom);
         i_cs = cs_ram; i_we = systemWe; i_addr = systemAddr; i_din = cpuDo;
         i_ack = sd.sdram_ack; i_dout = sd.sdram_dout;
         i_pause = pause; i_model = model;
         tp = t;
         tick();

         m_req = 0;
         m_ref_f = 0;
         if (i_ack) begin
            if (m_stale) m_stale = 0;
            else if (m_open && tp / P == m_slot && c > RA && c <= P - 2) begin
               m_open = 0;
               if (!m_we) m_data = i_dout;
            end
         end
         if (m_open && c == P - 2) begin
            m_open = 0;
            m_data_late = 1;
            m_data = 8'hFF;
            m_stale = 1;
         end
         if (c == RA - 1) begin
            if ((ph == 0 || !m_paused) && i_cs) begin
               m_req = 1;
               m_addr = i_addr; m_we = i_we; m_din = i_din;
               m_open = 1;
               m_slot = tp / P;
               ack_at = tp + 1 + int'($urandom_range(1, 15));
               ack_val = 8'($urandom);
            end else if (ph == 0 && (i_model || !i_cs) && m_ref == RC) begin
               m_ref_f = 1;
               m_ref = 0;
            end
         end
         if (c == P - 1 && ph == 1) begin
            if (m_ref < RC) m_ref++;
            m_paused = i_pause;
         end
      end
      sd.sdram_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/cbm2_bus_sequencer.md
# cbm2_bus_sequencer

Master bus-cycle generator for the CBM-II core. It divides `clk_sys` into the 2-phase system cycle: a video slot on phase 0 and a CPU slot on phase 1. It produces `phase`, `cpuCycle` and `vidCycle` for the bus decoder, and runs the SDRAM request/acknowledge handshake for any slot in which `cs_ram` is asserted, returning the captured byte as `ramData`. It also inserts DRAM refresh into unused video slots and produces the CPU/video clock-enable pulses.

## Interface
Parameters:
- `PHASE_CLKS`, 16: `clk_sys` cycles per phase. Must be even and ≥ 8. At 32 MHz the default gives a 1 MHz system cycle.
- `REQ_AT`, 2: count value within a slot at which `cs_ram` is sampled and the SDRAM request is issued.
- `REFRESH_CYCLES`, 15: maximum number of system cycles between refreshes.

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `pause` in 1: halts CPU slots, e.g. during ROM loading or OSD.
- `model` in 1: 0 = P2 (VIC uses DRAM), 1 = B2.
- `cs_ram` in 1: DRAM select from the bus decoder for the current slot.
- `systemAddr` in 25: address from the bus decoder.
- `systemWe` in 1: write qualifier from the bus decoder.
- `cpuDo` in 8: CPU write data.
- `phase` out 1: 0 = video slot, 1 = CPU slot.
- `cpuCycle` out 1: high for the whole CPU slot unless paused.
- `vidCycle` out 1: high for the whole video slot.
- `enableCpu` out 1: one-clock pulse on the last clock of a non-paused CPU slot.
- `enableVid` out 1: one-clock pulse on the last clock of each video slot.
- `sdram_req` out 1: one-clock request strobe.
- `sdram_we` out 1: write/read select, valid with `sdram_req`.
- `sdram_addr` out 25: address, valid with `sdram_req`.
- `sdram_din` out 8: write data, valid with `sdram_req`.
- `sdram_refresh` out 1: one-clock refresh strobe.
- `sdram_ack` in 1: one-clock completion pulse from the SDRAM controller.
- `sdram_dout` in 8: read data, valid when `sdram_ack` is high.
- `ramData` out 8: last read byte, held between accesses.
- `ramLate` out 1: sticky error flag, cleared only by reset.

## Operation
- Phase counter `cnt` runs 0..`PHASE_CLKS`-1. On wrap, `phase` toggles.
- Slot sampling: at `cnt == REQ_AT`, if the slot is active and `cs_ram` = 1, the block captures `systemAddr`, `systemWe` and `cpuDo`, then pulses `sdram_req` with `sdram_we = systemWe`. A slot is active when it is a video slot, or a CPU slot with `cpuCycle` = 1.
- Access FSM states: IDLE, WAIT, DONE.
  - IDLE → WAIT on `sdram_req`.
  - WAIT → DONE on `sdram_ack`. On a read, `sdram_dout` is latched into `ramData`.
  - WAIT → DONE at `cnt == PHASE_CLKS-2` without an ack: set `ramLate`, set `ramData` to 8'hFF, and ignore that access's ack if it arrives later.
  - DONE → IDLE at the slot wrap.
- Writes leave `ramData` unchanged.
- Refresh:
  - `refcnt` increments once per system cycle (at the phase 1→0 wrap) and saturates at `REFRESH_CYCLES`. Once it reaches `REFRESH_CYCLES`, a refresh is pending.
  - A pending refresh is issued only in a video slot with no DRAM access, with `sdram_refresh` pulsed at `cnt == REQ_AT`.
  - Issuing a refresh clears `refcnt` to 0.
  - When `model` = 1, every video slot qualifies.
  - A request and a refresh are never issued in the same slot; the request wins and the refresh stays pending.
- Pause: sampled at the phase 1→0 wrap. While it is latched, `cpuCycle` and `enableCpu` stay 0 and no CPU-slot DRAM request is made. Video slots and refresh continue normally. Releasing pause takes effect at the next wrap.

## Timing
- Reset values: `cnt` = 0, `phase` = 0, `vidCycle` = 1, `cpuCycle` = 0, every strobe = 0, `sdram_addr` = 0, `sdram_din` = 0, `ramData` = 8'hFF, `ramLate` = 0, `refcnt` = 0, FSM = IDLE.
- Reset mid-access aborts the access; any later `sdram_ack` is ignored.
- `cpuCycle` and `vidCycle` change only at the slot boundary, the clock after `cnt` wraps. They are mutually exclusive.
- `ramData` is valid the clock after `sdram_ack`. It is always valid by `cnt == PHASE_CLKS-1`, coincident with `enableCpu` / `enableVid`.
- An ack at `cnt == PHASE_CLKS-2` is accepted, because ack is checked before the timeout.
- A full system cycle is 2·`PHASE_CLKS` clocks. With no pause, `enableCpu` has exactly that period.

## Structure
- Package `cbm2_pkg` holds the FSM state enum (`acc_state_t`) and the default constants for `PHASE_CLKS`, `REQ_AT` and `REFRESH_CYCLES`.
- Sub-module `cbm2_refresh_timer` contains `refcnt`, the pending flag and the issue/clear logic. Everything else stays in the top module.

## Test plan
- Reset, then free-run 64 clocks → `phase` toggles every 16 clocks; `enableVid` pulses at clocks 15 and 47; `enableCpu` pulses at clocks 31 and 63.
- CPU read with `cs_ram`=1, `systemAddr`=25'h012345, ack 4 clocks after `sdram_req` carrying 8'hA5 → `sdram_req` pulses at `cnt`=2 with `sdram_addr` = 25'h012345 and `sdram_we`=0; `ramData`=8'hA5 before `enableCpu`.
- CPU write of 8'h3C → `sdram_we`=1 and `sdram_din`=8'h3C; `ramData` unchanged.
- Ack withheld for a whole slot → `ramLate`=1 and `ramData`=8'hFF at `cnt`=15; an ack arriving in the next slot is ignored.
- `model`=0 with `cs_ram`=1 in every video slot for 20 cycles, then `cs_ram`=0 → no refresh while busy; `sdram_refresh` in the first free video slot; next refresh 15 cycles later.
- Raise `pause` mid-CPU-slot, hold it for 3 cycles → the current slot completes; the next 3 CPU slots have `cpuCycle`=0 and no `enableCpu`; video pulses continue.
